// File: rtl/bias_rd_sched.sv
// Bias buffer read scheduler: issues a wrapping burst of SRAM reads around host accesses,
// absorbs the fixed read latency in a credit-controlled FIFO and streams words to the bias loader.

module bias_rd_sched_chk (
   input logic i_clk,
   input logic i_rst_n,
   input logic push,
   input logic full
);
   // A returning word must always find a free FIFO slot.
   assert property (@(posedge i_clk) disable iff (!i_rst_n) !(push && full));
endmodule

module bias_rd_sched #(
   parameter int ADDR_WD    = 7,
   parameter int DATA_WD    = 512,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [ADDR_WD-1:0] i_base_addr,
   input  logic [ADDR_WD:0]   i_num,
   input  logic               i_clr,
   output logic               o_busy,
   output logic               o_done,
   input  logic               i_host_en,
   output logic               o_buf_rd_en,
   output logic [ADDR_WD-1:0] o_buf_rd_addr,
   input  logic [DATA_WD-1:0] i_buf_dat,
   output logic [DATA_WD-1:0] o_bias_dat,
   output logic               o_bias_vld,
   input  logic               i_bias_rdy,
   output logic               o_bias_last
);
   localparam int PTR_WD = $clog2(FIFO_DEPTH);
   localparam int CR_WD  = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_r;
   logic [ADDR_WD-1:0] base_r;
   logic [ADDR_WD:0]   num_r;
   logic [ADDR_WD:0]   issue_cnt_r;
   logic [ADDR_WD:0]   pop_cnt_r;
   logic               busy_r;
   logic               done_r;
   logic [RD_LAT-1:0]  pipe_r;
   logic [DATA_WD-1:0] fifo_mem_r [FIFO_DEPTH];
   logic [PTR_WD-1:0]  wr_ptr_r;
   logic [PTR_WD-1:0]  rd_ptr_r;
   logic [PTR_WD:0]    fifo_cnt_r;

   logic [CR_WD-1:0]   inflight_s;
   logic [CR_WD-1:0]   credit_s;
   logic               rd_en_s;
   logic               push_s;
   logic               pop_s;
   logic               vld_s;
   logic               full_s;
   logic [ADDR_WD:0]   pop_cnt_nxt_s;

   // Reads in flight plus words buffered; a pop this cycle only frees its slot next cycle.
   always_comb begin
      inflight_s = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight_s = inflight_s + CR_WD'(pipe_r[i]);
      end
      credit_s = inflight_s + CR_WD'(fifo_cnt_r);
   end

   // Host always wins the port; clear suppresses any new read in its own cycle.
   always_comb begin
      if ((state_r == ST_RUN) && !i_host_en && !i_clr &&
          (credit_s < CR_WD'(FIFO_DEPTH)) && (issue_cnt_r < num_r)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   assign push_s        = pipe_r[RD_LAT-1];
   assign vld_s         = (fifo_cnt_r != '0);
   assign pop_s         = vld_s & i_bias_rdy;
   assign full_s        = (fifo_cnt_r == (PTR_WD+1)'(FIFO_DEPTH));
   assign pop_cnt_nxt_s = pop_cnt_r + {{ADDR_WD{1'b0}}, pop_s};

   // Burst control FSM with registered busy/done.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= ST_IDLE;
         base_r      <= '0;
         num_r       <= '0;
         issue_cnt_r <= '0;
         pop_cnt_r   <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else if (i_clr) begin
         state_r     <= ST_IDLE;
         base_r      <= '0;
         num_r       <= '0;
         issue_cnt_r <= '0;
         pop_cnt_r   <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         pop_cnt_r <= pop_cnt_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (i_start) begin
                  base_r      <= i_base_addr;
                  num_r       <= i_num;
                  issue_cnt_r <= '0;
                  pop_cnt_r   <= '0;
                  busy_r      <= 1'b1;
                  if (i_num == '0) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (rd_en_s) begin
                  issue_cnt_r <= issue_cnt_r + (ADDR_WD+1)'(1);
                  if ((issue_cnt_r + (ADDR_WD+1)'(1)) == num_r) begin
                     state_r <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Every read is issued, so a full pop count means pipe and FIFO are empty.
               if (pop_cnt_nxt_s == num_r) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Read-latency pipe: the flag leaving the last stage marks valid buffer data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pipe_r <= '0;
      end else if (i_clr) begin
         pipe_r <= '0;
      end else begin
         pipe_r[0] <= rd_en_s;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         fifo_cnt_r <= '0;
      end else if (i_clr) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         fifo_cnt_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_WD'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_WD'(1);
         end
         fifo_cnt_r <= fifo_cnt_r + (PTR_WD+1)'(push_s) - (PTR_WD+1)'(pop_s);
      end
   end

   // FIFO storage; contents are only visible through a valid head.
   always_ff @(posedge i_clk) begin
      if (push_s && !i_clr) begin
         fifo_mem_r[wr_ptr_r] <= i_buf_dat;
      end
   end

   assign o_busy        = busy_r;
   assign o_done        = done_r;
   assign o_buf_rd_en   = rd_en_s;
   assign o_buf_rd_addr = base_r + issue_cnt_r[ADDR_WD-1:0];
   assign o_bias_vld    = vld_s;
   assign o_bias_dat    = vld_s ? fifo_mem_r[rd_ptr_r] : '0;
   assign o_bias_last   = vld_s & (pop_cnt_r == (num_r - (ADDR_WD+1)'(1)));

   bias_rd_sched_chk u_chk (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (push_s),
      .full    (full_s)
   );
endmodule

// File: tb/tb_bias_rd_sched.sv
// Directed bench for bias_rd_sched: table of bursts plus clear/reset abort sequences,
// against a 2-cycle-latency SRAM model preloaded with known words.

module tb_bias_rd_sched;
   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_start;
   logic [6:0]   i_base_addr;
   logic [7:0]   i_num;
   logic         i_clr;
   logic         o_busy;
   logic         o_done;
   logic         i_host_en;
   logic         o_buf_rd_en;
   logic [6:0]   o_buf_rd_addr;
   logic [511:0] i_buf_dat;
   logic [511:0] o_bias_dat;
   logic         o_bias_vld;
   logic         i_bias_rdy;
   logic         o_bias_last;

   int total = 0;
   int bad   = 0;

   logic [511:0] mem [128];
   logic [511:0] sram_q1;

   typedef struct {
      logic [6:0]  base;
      logic [7:0]  num;
      logic [31:0] host;
      int          rdy_low;
      int          restart;
      int          exp_first_vld;
      int          exp_iss_hold;
      int          exp_done;
   } vec_t;

   vec_t vecs [6];

   bias_rd_sched dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_base_addr   (i_base_addr),
      .i_num         (i_num),
      .i_clr         (i_clr),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .i_host_en     (i_host_en),
      .o_buf_rd_en   (o_buf_rd_en),
      .o_buf_rd_addr (o_buf_rd_addr),
      .i_buf_dat     (i_buf_dat),
      .o_bias_dat    (o_bias_dat),
      .o_bias_vld    (o_bias_vld),
      .i_bias_rdy    (i_bias_rdy),
      .o_bias_last   (o_bias_last)
   );

   always #5 i_clk = ~i_clk;

   // SRAM with registered output: data two cycles after the read enable.
   always @(posedge i_clk) begin
      if (o_buf_rd_en) sram_q1 <= mem[o_buf_rd_addr];
      else             sram_q1 <= {16{32'hDEADBEEF}};
      i_buf_dat <= sram_q1;
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic quiet(input string name, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(negedge i_clk);
         chk(name, 512'({o_busy, o_done, o_bias_vld, o_buf_rd_en, o_bias_last}), 512'(0));
      end
      @(posedge i_clk); #1;
   endtask

   task automatic run_vec(input vec_t v);
      int           n_iss = 0;
      int           n_pop = 0;
      int           first_vld = -1;
      int           done_t = -1;
      int           iss_hold = -1;
      logic         holding = 1'b0;
      logic [511:0] hold_dat = '0;
      logic [6:0]   ea;
      i_base_addr = v.base;
      i_num       = v.num;
      i_start     = 1'b1;
      i_host_en   = v.host[0];
      i_bias_rdy  = (v.rdy_low > 0) ? 1'b0 : 1'b1;
      for (int t = 0; t < 80 && done_t < 0; t++) begin
         @(negedge i_clk);
         chk("host_excl", 512'(o_buf_rd_en & i_host_en), 512'(0));
         if (o_buf_rd_en) begin
            ea = v.base + 7'(n_iss);
            chk("rd_addr", 512'(o_buf_rd_addr), 512'(ea));
            n_iss++;
         end
         if (o_bias_vld) begin
            if (first_vld < 0) first_vld = t;
            if (holding) chk("dat_stable", o_bias_dat, hold_dat);
         end
         if (o_bias_vld && i_bias_rdy) begin
            ea = v.base + 7'(n_pop);
            chk("bias_dat", o_bias_dat, mem[ea]);
            chk("bias_last", 512'(o_bias_last), 512'(n_pop == int'(v.num) - 1));
            n_pop++;
            holding = 1'b0;
         end else if (o_bias_vld) begin
            hold_dat = o_bias_dat;
            holding  = 1'b1;
         end else begin
            chk("last_no_vld", 512'(o_bias_last), 512'(0));
         end
         if (t == v.rdy_low - 1) iss_hold = n_iss;
         if (o_done) begin
            done_t = t;
            chk("busy_at_done", 512'(o_busy), 512'(1));
         end
         @(posedge i_clk); #1;
         i_start = (t + 1 == v.restart);
         if (t + 1 == v.restart) begin
            i_base_addr = 7'd99;
            i_num       = 8'd2;
         end
         i_host_en  = (t + 1 < 32) ? v.host[t+1] : 1'b0;
         i_bias_rdy = (t + 1 >= v.rdy_low);
      end
      @(negedge i_clk);
      chk("done_one_cycle", 512'(o_done), 512'(0));
      chk("busy_after", 512'(o_busy), 512'(0));
      chk("n_issued", 512'(n_iss), 512'(v.num));
      chk("n_popped", 512'(n_pop), 512'(v.num));
      chk("done_cycle", 512'(done_t), 512'(v.exp_done));
      chk("first_vld", 512'(first_vld), 512'(v.exp_first_vld));
      if (v.rdy_low > 0) chk("iss_credit", 512'(iss_hold), 512'(v.exp_iss_hold));
      @(posedge i_clk); #1;
      i_host_en  = 1'b0;
      i_bias_rdy = 1'b1;
   endtask

   task automatic start_abort(input logic [6:0] base, input logic [7:0] num);
      i_base_addr = base;
      i_num       = num;
      i_start     = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i] = {16{(32'(i) * 32'h9E3779B1) + 32'h00001234}};
      end
      vecs[0] = '{7'd0,   8'd8, 32'h0,  0,  3, 4,  0, 12};
      vecs[1] = '{7'd126, 8'd4, 32'h0,  0,  0, 4,  0, 8};
      vecs[2] = '{7'd0,   8'd8, 32'h0,  10, 0, 4,  4, 18};
      vecs[3] = '{7'd0,   8'd6, 32'h54, 0,  0, 4,  0, 13};
      vecs[4] = '{7'd10,  8'd0, 32'h0,  0,  0, -1, 0, 1};
      vecs[5] = '{7'd5,   8'd1, 32'h0,  0,  0, 4,  0, 5};

      i_rst_n     = 1'b0;
      i_start     = 1'b0;
      i_base_addr = '0;
      i_num       = '0;
      i_clr       = 1'b0;
      i_host_en   = 1'b0;
      i_bias_rdy  = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("rst_ctrl", 512'({o_busy, o_done, o_bias_vld, o_buf_rd_en, o_bias_last}), 512'(0));
      chk("rst_addr", 512'(o_buf_rd_addr), 512'(0));
      chk("rst_dat", o_bias_dat, 512'(0));
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      quiet("idle_quiet", 2);

      for (int v = 0; v < 6; v++) begin
         run_vec(vecs[v]);
      end

      // Clear mid-burst: two reads in flight when i_clr is applied.
      start_abort(7'd0, 8'd8);
      i_clr = 1'b1;
      @(negedge i_clk);
      chk("rd_en_in_clr", 512'(o_buf_rd_en), 512'(0));
      @(posedge i_clk); #1;
      i_clr = 1'b0;
      quiet("clr_quiet", 6);
      run_vec('{7'd40, 8'd1, 32'h0, 0, 0, 4, 0, 5});

      // Clear wins over a simultaneous start.
      i_clr       = 1'b1;
      i_start     = 1'b1;
      i_base_addr = 7'd3;
      i_num       = 8'd2;
      @(posedge i_clk); #1;
      i_clr   = 1'b0;
      i_start = 1'b0;
      quiet("clr_start_prio", 4);

      // Asynchronous reset mid-burst with reads in flight.
      start_abort(7'd20, 8'd8);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      chk("rst_mid_ctrl", 512'({o_busy, o_done, o_bias_vld, o_buf_rd_en}), 512'(0));
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      quiet("rst_quiet", 6);
      run_vec('{7'd41, 8'd1, 32'h0, 0, 0, 4, 0, 5});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
